mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_if.sv | 51 +++++
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Cache-side and memory-bus-side signals of the refill arbiter.
// master: the arbiter's view. slave: the environment's view (caches and bus).
interface mem_bus_arbiter_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      ic_req;
  logic [BUS_DATA_WIDTH-1:0] ic_addr;
  logic [BUS_TAG_WIDTH-1:0]  ic_tag;
  logic                      ic_grant;
  logic                      ic_resp_valid;
  logic [BUS_DATA_WIDTH-1:0] ic_resp_data;
  logic                      ic_done;

  logic                      dc_req;
  logic [BUS_DATA_WIDTH-1:0] dc_addr;
  logic [BUS_TAG_WIDTH-1:0]  dc_tag;
  logic                      dc_grant;
  logic                      dc_resp_valid;
  logic [BUS_DATA_WIDTH-1:0] dc_resp_data;
  logic                      dc_done;

  logic                      bus_req;
  logic [BUS_DATA_WIDTH-1:0] bus_reqaddr;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport master (
    input  ic_req, ic_addr, ic_tag,
    output ic_grant, ic_resp_valid, ic_resp_data, ic_done,
    input  dc_req, dc_addr, dc_tag,
    output dc_grant, dc_resp_valid, dc_resp_data, dc_done,
    output bus_req, bus_reqaddr, bus_reqtag,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output bus_respack
  );

  modport slave (
    output ic_req, ic_addr, ic_tag,
    input  ic_grant, ic_resp_valid, ic_resp_data, ic_done,
    output dc_req, dc_addr, dc_tag,
    input  dc_grant, dc_resp_valid, dc_resp_data, dc_done,
    input  bus_req, bus_reqaddr, bus_reqtag,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  bus_respack
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter for I-cache / D-cache line refills.
// One requester owns the bus from grant until its line (BEATS beats) is done.
// Build option: define ARB_DCACHE_PRIORITY_EN for fixed D-cache priority;
// otherwise the two caches alternate round-robin when both request.
//
// state | meaning
// IDLE  | no owner; pick a requester and latch its address/tag
// REQ   | bus_req driven with latched address/tag until bus_reqack
// RESP  | forward response beats to the owner, count them
// DONE  | one-cycle done pulse to the owner, then release
module mem_bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_arbiter_if.master   arb
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                    state, state_nxt;
  logic                      owner, owner_nxt;   // 0 = I-cache, 1 = D-cache
  logic                      ptr, ptr_nxt;       // preferred requester on a tie
  logic [CW-1:0]             cnt, cnt_nxt;
  logic [BUS_DATA_WIDTH-1:0] addr_q, addr_nxt;
  logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_nxt;
  logic                      pick_dc;

  // Response tag is not used for routing; only the latched owner matters.
  logic unused_ok;
  assign unused_ok = ^{arb.bus_resptag, ptr};

  // State and latched transaction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      ptr    <= 1'b0;
      cnt    <= '0;
      addr_q <= '0;
      tag_q  <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      ptr    <= ptr_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      tag_q  <= tag_nxt;
    end
  end

  // Next-state, arbitration and output decode.
  always_comb begin
    state_nxt         = state;
    owner_nxt         = owner;
    ptr_nxt           = ptr;
    cnt_nxt           = cnt;
    addr_nxt          = addr_q;
    tag_nxt           = tag_q;
    pick_dc           = 1'b0;

    arb.ic_grant      = 1'b0;
    arb.ic_resp_valid = 1'b0;
    arb.ic_resp_data  = '0;
    arb.ic_done       = 1'b0;
    arb.dc_grant      = 1'b0;
    arb.dc_resp_valid = 1'b0;
    arb.dc_resp_data  = '0;
    arb.dc_done       = 1'b0;
    arb.bus_req       = 1'b0;
    arb.bus_reqaddr   = '0;
    arb.bus_reqtag    = '0;
    arb.bus_respack   = 1'b0;

    // Grant is held from the REQ cycle through the DONE cycle.
    if (state != IDLE) begin
      arb.ic_grant = ~owner;
      arb.dc_grant = owner;
    end

    case (state)
      IDLE: begin
        if (arb.ic_req || arb.dc_req) begin
`ifdef ARB_DCACHE_PRIORITY_EN
          pick_dc = arb.dc_req;
`else
          pick_dc = arb.dc_req && (!arb.ic_req || ptr);
`endif
          owner_nxt = pick_dc;
          addr_nxt  = pick_dc ? arb.dc_addr : arb.ic_addr;
          tag_nxt   = pick_dc ? arb.dc_tag  : arb.ic_tag;
          state_nxt = REQ;
        end
      end

      REQ: begin
        arb.bus_req     = 1'b1;
        arb.bus_reqaddr = addr_q;
        arb.bus_reqtag  = tag_q;
        if (arb.bus_reqack) begin
          cnt_nxt   = '0;
          state_nxt = RESP;
        end
      end

      RESP: begin
        arb.bus_respack = arb.bus_respcyc;
        if (owner) begin
          arb.dc_resp_valid = arb.bus_respcyc;
          arb.dc_resp_data  = arb.bus_resp;
        end else begin
          arb.ic_resp_valid = arb.bus_respcyc;
          arb.ic_resp_data  = arb.bus_resp;
        end
        if (arb.bus_respcyc) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST_BEAT) state_nxt = DONE;
        end
      end

      DONE: begin
        arb.ic_done = ~owner;
        arb.dc_done = owner;
`ifdef ARB_DCACHE_PRIORITY_EN
        ptr_nxt = 1'b0;
`else
        ptr_nxt = ~owner;
`endif
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: the main sequence pushes the expected
// bus requests, beats and done pulses; a negedge monitor pops and compares.
module tb_mem_bus_arbiter;
  localparam int DW = 64;
  localparam int TW = 13;

  typedef enum int {EV_REQ = 0, EV_BEAT = 1, EV_DONE = 2} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic          who;      // 0 = ic, 1 = dc
    logic [DW-1:0] val;      // address for EV_REQ, data for EV_BEAT
    logic [TW-1:0] tag;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus_if ();

  mem_bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus_if)
  );

  ev_t           expq[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            beats_seen = 0;
  int            done_count = 0;
  int            last_beat_cyc = 0;
  logic          prev_bus_req = 1'b0;
  logic [DW-1:0] cur_addr = '0;
  logic [TW-1:0] cur_tag = '0;
  ev_t           mon_ev;
  bit            mon_ok;

  int            ack_delay = 0;
  int            pat[$];
  int            txn_no = 0;
  int            ic_left = 0;
  int            dc_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pop_ev(input string name, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{EV_REQ, 1'b0, '0, '0};
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s actual=event required=none", name);
    end else begin
      e  = expq.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic push_txn(input logic who, input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                          input int txn, input int nbeats, input bit with_done);
    expq.push_back('{EV_REQ, who, addr, tag});
    for (int i = 0; i < nbeats; i++) expq.push_back('{EV_BEAT, who, DW'(txn * 256 + i), '0});
    if (with_done) expq.push_back('{EV_DONE, who, '0, '0});
  endtask

  task automatic check_idle_outputs(input string tag_name);
    check({tag_name, "_ic_grant"},  64'(bus_if.ic_grant), 64'd0);
    check({tag_name, "_dc_grant"},  64'(bus_if.dc_grant), 64'd0);
    check({tag_name, "_ic_valid"},  64'(bus_if.ic_resp_valid), 64'd0);
    check({tag_name, "_dc_valid"},  64'(bus_if.dc_resp_valid), 64'd0);
    check({tag_name, "_ic_done"},   64'(bus_if.ic_done), 64'd0);
    check({tag_name, "_dc_done"},   64'(bus_if.dc_done), 64'd0);
    check({tag_name, "_bus_req"},   64'(bus_if.bus_req), 64'd0);
    check({tag_name, "_reqaddr"},   bus_if.bus_reqaddr, 64'd0);
    check({tag_name, "_reqtag"},    64'(bus_if.bus_reqtag), 64'd0);
    check({tag_name, "_respack"},   64'(bus_if.bus_respack), 64'd0);
  endtask

  task automatic wait_done(input int n, input int limit);
    int start;
    int c;
    start = done_count;
    c = 0;
    while (done_count < start + n && c < limit) begin
      @(posedge clk);
      c++;
    end
    if (done_count < start + n) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout actual=%0d required=%0d", done_count - start, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: per-cycle invariants plus in-order scoreboard of bus events.
  always @(negedge clk) begin
    cyc++;
    check("grant_exclusive", 64'(bus_if.ic_grant & bus_if.dc_grant), 64'd0);
    check("respack_mirror", 64'(bus_if.bus_respack), 64'(bus_if.bus_respcyc));
    check("route_exclusive", 64'(bus_if.ic_resp_valid & bus_if.dc_resp_valid), 64'd0);

    if (bus_if.bus_req) begin
      if (!prev_bus_req) begin
        pop_ev("req", mon_ev, mon_ok);
        if (mon_ok) begin
          check("req_kind", 64'(mon_ev.kind), 64'(EV_REQ));
          check("req_addr", bus_if.bus_reqaddr, mon_ev.val);
          check("req_tag", 64'(bus_if.bus_reqtag), 64'(mon_ev.tag));
          check("req_grant", 64'(mon_ev.who ? bus_if.dc_grant : bus_if.ic_grant), 64'd1);
          cur_addr = mon_ev.val;
          cur_tag  = mon_ev.tag;
        end
      end else begin
        check("req_addr_hold", bus_if.bus_reqaddr, cur_addr);
        check("req_tag_hold", 64'(bus_if.bus_reqtag), 64'(cur_tag));
      end
    end
    prev_bus_req = bus_if.bus_req;

    if (bus_if.ic_resp_valid || bus_if.dc_resp_valid) begin
      beats_seen++;
      last_beat_cyc = cyc;
      pop_ev("beat", mon_ev, mon_ok);
      if (mon_ok) begin
        check("beat_kind", 64'(mon_ev.kind), 64'(EV_BEAT));
        check("beat_owner", 64'(bus_if.dc_resp_valid), 64'(mon_ev.who));
        check("beat_data", bus_if.dc_resp_valid ? bus_if.dc_resp_data : bus_if.ic_resp_data,
              mon_ev.val);
      end
    end

    if (bus_if.ic_done || bus_if.dc_done) begin
      done_count++;
      pop_ev("done", mon_ev, mon_ok);
      if (mon_ok) begin
        check("done_kind", 64'(mon_ev.kind), 64'(EV_DONE));
        check("done_owner", 64'(bus_if.dc_done), 64'(mon_ev.who));
        check("done_after_last_beat", 64'(cyc), 64'(last_beat_cyc + 1));
        check("done_grant", 64'(mon_ev.who ? bus_if.dc_grant : bus_if.ic_grant), 64'd1);
      end
    end
  end

  // Memory bus model: acks after ack_delay cycles, then plays pat (1 = beat).
  initial begin
    int k;
    bus_if.bus_reqack  = 1'b0;
    bus_if.bus_respcyc = 1'b0;
    bus_if.bus_resp    = '0;
    bus_if.bus_resptag = '0;
    forever begin
      @(posedge clk); #1;
      if (bus_if.bus_req && !reset) begin
        repeat (ack_delay) begin @(posedge clk); #1; end
        bus_if.bus_reqack = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_reqack = 1'b0;
        k = 0;
        for (int i = 0; i < pat.size(); i++) begin
          if (reset) break;
          bus_if.bus_respcyc = (pat[i] != 0);
          bus_if.bus_resp    = (pat[i] != 0) ? DW'(txn_no * 256 + k) : 64'hDEAD_BEEF;
          bus_if.bus_resptag = TW'(txn_no);
          if (pat[i] != 0) k++;
          @(posedge clk); #1;
        end
        bus_if.bus_respcyc = 1'b0;
        txn_no++;
      end
    end
  end

  // Requesters: hold req until the requested number of done pulses is seen.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus_if.ic_done && ic_left > 0) begin
        ic_left--;
        if (ic_left == 0) bus_if.ic_req = 1'b0;
      end
      if (bus_if.dc_done && dc_left > 0) begin
        dc_left--;
        if (dc_left == 0) bus_if.dc_req = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int b0;
    int c;
    int d0;
    bus_if.ic_req  = 1'b0;
    bus_if.ic_addr = '0;
    bus_if.ic_tag  = '0;
    bus_if.dc_req  = 1'b0;
    bus_if.dc_addr = '0;
    bus_if.dc_tag  = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Single I-cache request, ack two cycles later, 8 back-to-back beats 0..7
    ack_delay = 2;
    pat = '{1, 1, 1, 1, 1, 1, 1, 1};
    t = txn_no;
    push_txn(1'b0, 64'h1000, 13'h500, t, 8, 1'b1);
    bus_if.ic_addr = 64'h1000;
    bus_if.ic_tag  = 13'h500;
    bus_if.dc_addr = 64'h2040;
    bus_if.dc_tag  = 13'h0AB;
    ic_left = 1;
    bus_if.ic_req = 1'b1;
    wait_done(1, 200);

    // Both requesting from reset, held high across several transactions
    do_reset();
    ack_delay = 0;
    t = txn_no;
`ifdef ARB_DCACHE_PRIORITY_EN
    push_txn(1'b1, 64'h2040, 13'h0AB, t,     8, 1'b1);
    push_txn(1'b1, 64'h2040, 13'h0AB, t + 1, 8, 1'b1);
    push_txn(1'b1, 64'h2040, 13'h0AB, t + 2, 8, 1'b1);
    push_txn(1'b0, 64'h1000, 13'h500, t + 3, 8, 1'b1);
    ic_left = 1;
    dc_left = 3;
`else
    push_txn(1'b0, 64'h1000, 13'h500, t,     8, 1'b1);
    push_txn(1'b1, 64'h2040, 13'h0AB, t + 1, 8, 1'b1);
    push_txn(1'b0, 64'h1000, 13'h500, t + 2, 8, 1'b1);
    push_txn(1'b1, 64'h2040, 13'h0AB, t + 3, 8, 1'b1);
    ic_left = 2;
    dc_left = 2;
`endif
    bus_if.ic_req = 1'b1;
    bus_if.dc_req = 1'b1;
    wait_done(4, 600);

    // Gapped response stream on a D-cache refill
    ack_delay = 1;
    pat = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    t = txn_no;
    push_txn(1'b1, 64'h2040, 13'h0AB, t, 8, 1'b1);
    dc_left = 1;
    bus_if.dc_req = 1'b1;
    wait_done(1, 200);

    // Reset during RESP after three beats, landing in a response gap
    ack_delay = 1;
    pat = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    t = txn_no;
    push_txn(1'b0, 64'h1000, 13'h500, t, 3, 1'b0);
    b0 = beats_seen;
    d0 = done_count;
    ic_left = 1;
    bus_if.ic_req = 1'b1;
    c = 0;
    while (beats_seen < b0 + 3 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check("beats_before_reset", 64'(beats_seen - b0), 64'd3);
    reset = 1'b1;
    bus_if.ic_req = 1'b0;
    ic_left = 0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_on_reset", 64'(done_count - d0), 64'd0);
    check("reset_queue_drained", 64'(expq.size()), 64'd0);

    // Fresh D-cache request after the abandoned one
    ack_delay = 2;
    pat = '{1, 1, 1, 1, 1, 1, 1, 1};
    t = txn_no;
    push_txn(1'b1, 64'h2040, 13'h0AB, t, 8, 1'b1);
    dc_left = 1;
    bus_if.dc_req = 1'b1;
    wait_done(1, 200);

    // D-cache drops its request after grant, before reqack
    ack_delay = 3;
    t = txn_no;
    push_txn(1'b1, 64'h2040, 13'h0AB, t, 8, 1'b1);
    dc_left = 1;
    bus_if.dc_req = 1'b1;
    c = 0;
    while (!bus_if.dc_grant && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check("drop_grant_seen", 64'(bus_if.dc_grant), 64'd1);
    bus_if.dc_req = 1'b0;
    wait_done(1, 200);
    @(negedge clk);
    check("drop_idle_grant", 64'(bus_if.dc_grant), 64'd0);
    check("drop_idle_bus_req", 64'(bus_if.bus_req), 64'd0);

    check("queue_empty_at_end", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
